// File: rtl/lzc_norm_pipe_if.sv
// Valid/ready bundle for lzc_norm_pipe: operand side (in_*) and result side (out_*).
// WIDTH and TAG_W must match the parameters of the attached lzc_norm_pipe.
interface lzc_norm_pipe_if #(
  parameter int WIDTH = 64,
  parameter int TAG_W = 4
);
  localparam int CNT_W = $clog2(WIDTH + 1);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             in_mode;
  logic [TAG_W-1:0] in_tag;

  logic             out_valid;
  logic             out_ready;
  logic [CNT_W-1:0] out_count;
  logic             out_zero;
  logic [WIDTH-1:0] out_data;
  logic [TAG_W-1:0] out_tag;

  modport master (
    output in_valid, in_data, in_mode, in_tag, out_ready,
    input  in_ready, out_valid, out_count, out_zero, out_data, out_tag
  );

  modport slave (
    input  in_valid, in_data, in_mode, in_tag, out_ready,
    output in_ready, out_valid, out_count, out_zero, out_data, out_tag
  );
endinterface

// File: rtl/lzc_norm_pipe.sv
// Pipelined leading-zero/leading-one counter with optional left normaliser.
// Define LZC_NORM_SHIFT_EN to build the barrel shifter; otherwise out_data is tied to 0.
module lzc_norm_pipe #(
  parameter int WIDTH  = 64,
  parameter int STAGES = 2,
  parameter int TAG_W  = 4
) (
  input  logic           clk,
  input  logic           rst,
  lzc_norm_pipe_if.slave bus
);
  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam int NL    = (WIDTH + 7) / 8;
  localparam int PW    = NL * 8;
  localparam int LAST  = STAGES - 1;

  // Mode 1 is folded into mode 0 by inverting the operand; pads below the LSB are 1s
  // so they always terminate the run and are never counted.
  logic [WIDTH-1:0] norm_op;
  logic [PW-1:0]    pad_op;

  assign norm_op = bus.in_mode ? ~bus.in_data : bus.in_data;

  always_comb begin
    pad_op                 = '1;
    pad_op[PW-1 -: WIDTH]  = norm_op;
  end

  logic [NL-1:0] leaf_nz;
  logic [2:0]    leaf_lz [NL];

  generate
    for (genvar gi = 0; gi < NL; gi++) begin : g_leaf
      logic [7:0] leaf_bits;
      logic [2:0] lz;

      assign leaf_bits = pad_op[PW-1-8*gi -: 8];

      always_comb begin
        lz = 3'd0;
        for (int b = 0; b < 8; b++) begin
          if (leaf_bits[b]) lz = 3'(7 - b);
        end
      end

      assign leaf_nz[gi] = |leaf_bits;
      assign leaf_lz[gi] = lz;
    end
  endgenerate

  logic [CNT_W-1:0] in_cnt;

  always_comb begin
    in_cnt = CNT_W'(WIDTH);
    for (int l = NL - 1; l >= 0; l--) begin
      if (leaf_nz[l]) in_cnt = CNT_W'(8 * l) + CNT_W'(leaf_lz[l]);
    end
  end

  // Pipeline slots: a slot may load when it is empty or its content moves on this cycle.
  logic [STAGES-1:0] valid_q, valid_d, load, src_v;
  logic [CNT_W-1:0]  cnt_q [STAGES];
  logic [CNT_W-1:0]  cnt_d [STAGES];
  logic [CNT_W-1:0]  src_cnt [STAGES];
  logic [TAG_W-1:0]  tag_q [STAGES];
  logic [TAG_W-1:0]  tag_d [STAGES];
  logic [TAG_W-1:0]  src_tag [STAGES];
  logic              in_ready_w;
  logic              accept;

  always_comb begin
    logic down_ok;
    down_ok = bus.out_ready;
    load    = '0;
    for (int k = LAST; k >= 0; k--) begin
      load[k] = !valid_q[k] || down_ok;
      down_ok = load[k];
    end
  end

  assign in_ready_w = !rst && load[0];
  assign accept     = bus.in_valid && in_ready_w;

  always_comb begin
    logic take;
    src_v      = '0;
    src_cnt    = '{default: '0};
    src_tag    = '{default: '0};
    valid_d    = valid_q;
    cnt_d      = cnt_q;
    tag_d      = tag_q;
    take       = 1'b0;
    src_v[0]   = accept;
    src_cnt[0] = in_cnt;
    src_tag[0] = bus.in_tag;
    for (int k = 1; k < STAGES; k++) begin
      src_v[k]   = valid_q[k-1];
      src_cnt[k] = cnt_q[k-1];
      src_tag[k] = tag_q[k-1];
    end
    for (int k = 0; k < STAGES; k++) begin
      take = load[k] && src_v[k];
      if (load[k]) valid_d[k] = src_v[k];
      if (take) begin
        cnt_d[k] = src_cnt[k];
        tag_d[k] = src_tag[k];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      cnt_q   <= '{default: '0};
      tag_q   <= '{default: '0};
    end else begin
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
      tag_q   <= tag_d;
    end
  end

`ifdef LZC_NORM_SHIFT_EN
  function automatic logic [WIDTH-1:0] shl_norm(input logic [WIDTH-1:0] d,
                                                 input logic [CNT_W-1:0] s);
    logic [WIDTH-1:0] r;
    r = d;
    for (int b = 0; b < CNT_W; b++) begin
      if (s[b]) r = r << (1 << b);
    end
    return r;
  endfunction

  logic [WIDTH-1:0] data_q   [STAGES];
  logic [WIDTH-1:0] data_d   [STAGES];
  logic [WIDTH-1:0] src_data [STAGES];

  // Raw operand rides the early slots; the shift happens on the way into the last slot.
  always_comb begin
    src_data    = '{default: '0};
    data_d      = data_q;
    src_data[0] = bus.in_data;
    for (int k = 1; k < STAGES; k++) src_data[k] = data_q[k-1];
    for (int k = 0; k < STAGES; k++) begin
      if (load[k] && src_v[k]) begin
        data_d[k] = (k == LAST) ? shl_norm(src_data[k], src_cnt[k]) : src_data[k];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) data_q <= '{default: '0};
    else     data_q <= data_d;
  end

  assign bus.out_data = data_q[LAST];
`else
  assign bus.out_data = '0;
`endif

  assign bus.in_ready  = in_ready_w;
  assign bus.out_valid = valid_q[LAST];
  assign bus.out_count = cnt_q[LAST];
  assign bus.out_zero  = (cnt_q[LAST] == CNT_W'(WIDTH));
  assign bus.out_tag   = tag_q[LAST];
endmodule

// File: tb/tb_lzc_norm_pipe.sv
// Randomised and directed bench for lzc_norm_pipe: a 64-bit/2-stage and a 53-bit/1-stage instance
// checked against a scoreboard fed by a plain-arithmetic leading-digit model.
module tb_lzc_norm_pipe;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst   = 1'b1;
  logic rst_d = 1'b1;

  lzc_norm_pipe_if #(.WIDTH(64), .TAG_W(4)) bus0 ();
  lzc_norm_pipe_if #(.WIDTH(53), .TAG_W(4)) bus1 ();

  lzc_norm_pipe #(.WIDTH(64), .STAGES(2), .TAG_W(4)) u_dut64 (.clk(clk), .rst(rst), .bus(bus0));
  lzc_norm_pipe #(.WIDTH(53), .STAGES(1), .TAG_W(4)) u_dut53 (.clk(clk), .rst(rst), .bus(bus1));

  logic [1:0]   in_valid_v  = '0;
  logic [1:0]   in_mode_v   = '0;
  logic [1:0]   out_ready_v = '1;
  logic [127:0] in_data_v [2];
  logic [3:0]   in_tag_v  [2];

  logic [1:0]   in_ready_v, out_valid_v, out_zero_v;
  logic [7:0]   out_count_v [2];
  logic [127:0] out_data_v  [2];
  logic [3:0]   out_tag_v   [2];

  assign bus0.in_valid  = in_valid_v[0];
  assign bus0.in_mode   = in_mode_v[0];
  assign bus0.in_data   = in_data_v[0][63:0];
  assign bus0.in_tag    = in_tag_v[0];
  assign bus0.out_ready = out_ready_v[0];
  assign bus1.in_valid  = in_valid_v[1];
  assign bus1.in_mode   = in_mode_v[1];
  assign bus1.in_data   = in_data_v[1][52:0];
  assign bus1.in_tag    = in_tag_v[1];
  assign bus1.out_ready = out_ready_v[1];

  assign in_ready_v[0]  = bus0.in_ready;
  assign out_valid_v[0] = bus0.out_valid;
  assign out_zero_v[0]  = bus0.out_zero;
  assign out_count_v[0] = 8'(bus0.out_count);
  assign out_data_v[0]  = 128'(bus0.out_data);
  assign out_tag_v[0]   = bus0.out_tag;
  assign in_ready_v[1]  = bus1.in_ready;
  assign out_valid_v[1] = bus1.out_valid;
  assign out_zero_v[1]  = bus1.out_zero;
  assign out_count_v[1] = 8'(bus1.out_count);
  assign out_data_v[1]  = 128'(bus1.out_data);
  assign out_tag_v[1]   = bus1.out_tag;

  int n_cmp = 0;
  int n_mis = 0;

  task automatic check(input string tag, input logic [159:0] got, input logic [159:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int dw(input int d);
    return (d == 0) ? 64 : 53;
  endfunction

  function automatic int dst(input int d);
    return (d == 0) ? 2 : 1;
  endfunction

  // Reference: walk down from the MSB until a digit differs from the counted one.
  function automatic int ref_count(input logic [127:0] x, input int w, input logic mode);
    for (int i = w - 1; i >= 0; i--) begin
      if (x[i] != mode) return w - 1 - i;
    end
    return w;
  endfunction

  function automatic logic [127:0] ref_data(input logic [127:0] x, input int w, input int cnt);
    logic [127:0] mask;
    mask = (128'd1 << w) - 128'd1;
`ifdef LZC_NORM_SHIFT_EN
    return (x << cnt) & mask;
`else
    return (cnt >= 0) ? 128'd0 : x & mask;
`endif
  endfunction

  function automatic logic [127:0] rnd_data(input int w, input logic mode);
    logic [127:0] x, mask;
    mask = (128'd1 << w) - 128'd1;
    x    = {$urandom, $urandom, $urandom, $urandom} & mask;
    x    = x >> $urandom_range(0, w);
    if (mode) x = ~x & mask;
    return x;
  endfunction

  typedef struct {
    int           dut;
    logic [7:0]   cnt;
    logic         zero;
    logic [127:0] data;
    logic [3:0]   tag;
    int           cyc;
  } exp_t;

  exp_t         sb[$];
  int           occ [2] = '{0, 0};
  int           cyc = 0;
  logic [1:0]   lat_en = '0;
  logic [1:0]   hold = '0;
  logic [140:0] held [2];

  task automatic monitor_dut(input int d);
    logic [140:0] now;
    logic         exp_rdy;
    int           idx;
    int           c;
    exp_t         e;
    now     = {out_count_v[d], out_zero_v[d], out_data_v[d], out_tag_v[d]};
    exp_rdy = !rst && ((occ[d] < dst(d)) || out_ready_v[d]);
    check($sformatf("d%0d_in_ready", d), 160'(in_ready_v[d]), 160'(exp_rdy));
    if (rst_d) check($sformatf("d%0d_reset_out", d), 160'({out_valid_v[d], now}), 160'd0);
    if (hold[d]) check($sformatf("d%0d_stall_hold", d), 160'({out_valid_v[d], now}),
                       160'({1'b1, held[d]}));
    if (rst) begin
      for (int i = sb.size() - 1; i >= 0; i--) if (sb[i].dut == d) sb.delete(i);
      occ[d]  = 0;
      hold[d] = 1'b0;
      return;
    end
    if (out_valid_v[d] && out_ready_v[d]) begin
      idx = -1;
      for (int i = sb.size() - 1; i >= 0; i--) if (sb[i].dut == d) idx = i;
      if (idx < 0) begin
        check($sformatf("d%0d_spurious_out_tag%0h", d, out_tag_v[d]), 160'd1, 160'd0);
      end else begin
        e = sb[idx];
        sb.delete(idx);
        occ[d]--;
        check($sformatf("d%0d_count", d), 160'(out_count_v[d]), 160'(e.cnt));
        check($sformatf("d%0d_zero", d), 160'(out_zero_v[d]), 160'(e.zero));
        check($sformatf("d%0d_data", d), 160'(out_data_v[d]), 160'(e.data));
        check($sformatf("d%0d_tag", d), 160'(out_tag_v[d]), 160'(e.tag));
        if (lat_en[d]) check($sformatf("d%0d_latency", d), 160'(cyc - e.cyc), 160'(dst(d)));
        $display("txn d%0d tag=%0h count=%0d zero=%0d data=%0h", d, out_tag_v[d],
                 out_count_v[d], out_zero_v[d], out_data_v[d]);
      end
    end
    hold[d] = out_valid_v[d] && !out_ready_v[d];
    held[d] = now;
    if (in_valid_v[d] && in_ready_v[d]) begin
      c      = ref_count(in_data_v[d], dw(d), in_mode_v[d]);
      e.dut  = d;
      e.cnt  = 8'(c);
      e.zero = (c == dw(d));
      e.data = ref_data(in_data_v[d], dw(d), c);
      e.tag  = in_tag_v[d];
      e.cyc  = cyc;
      sb.push_back(e);
      occ[d]++;
    end
  endtask

  always @(posedge clk) rst_d <= rst;

  always @(negedge clk) begin
    cyc++;
    for (int d = 0; d < 2; d++) monitor_dut(d);
  end

  // Downstream ready: 0 always-1, 1 pattern 1,0,0 repeating, 2 random, 3 always-0.
  int rdy_mode [2] = '{0, 0};
  int rdy_ph   [2] = '{0, 0};

  initial begin
    forever begin
      @(posedge clk);
      #1;
      for (int d = 0; d < 2; d++) begin
        case (rdy_mode[d])
          0:       out_ready_v[d] = 1'b1;
          1:       out_ready_v[d] = (rdy_ph[d] % 3 == 0);
          2:       out_ready_v[d] = 1'($urandom_range(0, 1));
          default: out_ready_v[d] = 1'b0;
        endcase
        rdy_ph[d]++;
      end
    end
  end

  task automatic send(input int d, input logic [127:0] data, input logic mode,
                      input logic [3:0] tag);
    int n;
    bit ok;
    in_valid_v[d] = 1'b1;
    in_data_v[d]  = data;
    in_mode_v[d]  = mode;
    in_tag_v[d]   = tag;
    n  = 0;
    ok = 1'b0;
    while (!ok && n < 200) begin
      @(negedge clk);
      ok = in_ready_v[d];
      @(posedge clk);
      #1;
      n++;
    end
    if (!ok) check($sformatf("d%0d_send_timeout", d), 160'd0, 160'd1);
  endtask

  task automatic idle(input int d);
    in_valid_v[d] = 1'b0;
  endtask

  task automatic drain(input int d);
    int n;
    rdy_mode[d] = 0;
    n = 0;
    while (occ[d] != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    @(posedge clk);
    #1;
    check($sformatf("d%0d_drain", d), 160'(occ[d]), 160'd0);
  endtask

  task automatic random_run(input int d, input int n);
    logic m;
    rdy_mode[d] = 2;
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        idle(d);
        @(posedge clk);
        #1;
      end
      m = 1'($urandom_range(0, 1));
      send(d, rnd_data(dw(d), m), m, 4'($urandom_range(0, 15)));
    end
    idle(d);
    drain(d);
  endtask

  initial begin
    in_data_v[0] = '0;
    in_data_v[1] = '0;
    in_tag_v[0]  = '0;
    in_tag_v[1]  = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Walking one and the corner operands, back to back, out_ready held high.
    lat_en[0] = 1'b1;
    for (int k = 0; k < 64; k++) send(0, 128'd1 << k, 1'b0, 4'(k));
    send(0, 128'd0, 1'b0, 4'hA);
    send(0, 128'h8000_0000_0000_0000, 1'b0, 4'hB);
    send(0, 128'hFFF0_0000_0000_0000, 1'b1, 4'hC);
    send(0, 128'hFFFF_FFFF_FFFF_FFFF, 1'b1, 4'hD);
    send(0, 128'h7FFF_FFFF_FFFF_FFFF, 1'b1, 4'hE);
    send(0, 128'h0000_0000_0012_3456, 1'b0, 4'hF);
    idle(0);
    drain(0);
    lat_en[0] = 1'b0;

    random_run(0, 300);

    // Ten back-to-back operands against a 1,0,0 ready pattern.
    rdy_ph[0]   = 0;
    rdy_mode[0] = 1;
    for (int t = 0; t < 10; t++) send(0, rnd_data(64, 1'b0), 1'b0, 4'(t));
    idle(0);
    drain(0);

    // Fill the pipe behind a blocked output, then reset with traffic still offered.
    rdy_mode[0] = 3;
    send(0, rnd_data(64, 1'b0), 1'b0, 4'h1);
    send(0, rnd_data(64, 1'b1), 1'b1, 4'h2);
    in_valid_v[0] = 1'b1;
    in_data_v[0]  = 128'h55;
    in_tag_v[0]   = 4'h3;
    @(posedge clk);
    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    idle(0);
    rdy_mode[0] = 0;
    repeat (5) @(posedge clk);
    #1;
    for (int t = 4; t < 9; t++) send(0, rnd_data(64, 1'b0), 1'b0, 4'(t));
    idle(0);
    drain(0);

    // Odd width, single stage.
    lat_en[1] = 1'b1;
    for (int k = 0; k < 53; k++) send(1, 128'd1 << k, 1'b0, 4'(k));
    send(1, 128'd0, 1'b0, 4'hA);
    send(1, (128'd1 << 53) - 128'd1, 1'b1, 4'hB);
    send(1, (128'd1 << 52) - 128'd1, 1'b1, 4'hC);
    send(1, 128'h1F_FFFF_FFFF_FFF0, 1'b1, 4'hD);
    idle(1);
    drain(1);
    lat_en[1] = 1'b0;

    random_run(1, 150);

    check("scoreboard_empty", 160'(sb.size()), 160'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, compared %0d", n_cmp);
    $fatal(1, "watchdog");
  end
endmodule
